// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: three requesters share one register-file write port.
// Latency: grant is combinational, the rf_* write is registered one edge after the transfer.
// Backpressure: a losing requester sees req_ready=0 and holds; flush withholds all grants.
// Ports: clk/rst_n; req_valid/req_rd/req_data in, req_ready out; flush in;
//        rf_we/rf_waddr/rf_wdata/wb_src registered write port; conflict_cnt perf counter.
module wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [5*NUM_REQ-1:0]           req_rd,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           flush,
    output logic                           rf_we,
    output logic [4:0]                     rf_waddr,
    output logic [DATA_WIDTH-1:0]          rf_wdata,
    output logic [1:0]                     wb_src,
    output logic [CNT_WIDTH-1:0]           conflict_cnt
);

    logic [1:0]            last_grant;
    logic [1:0]            start;
    logic [2:0]            cand;
    logic [1:0]            grant_idx;
    logic                  found;
    logic                  transfer;
    logic [4:0]            sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [1:0]            num_valid;
    logic                  conflict;

    // Search begins one past the last winner and wraps modulo 3.
    always_comb begin
        req_ready = '0;
        grant_idx = 2'd0;
        sel_rd    = '0;
        sel_data  = '0;
        found     = 1'b0;
        cand      = '0;
        start     = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        for (int k = 0; k < 3; k++) begin
            cand = {1'b0, start} + 3'(k);
            if (cand >= 3'd3) begin
                cand = cand - 3'd3;
            end
            if (!found && req_valid[cand[1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[1:0];
            end
        end
        if (flush) begin
            found = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && grant_idx == i[1:0]) begin
                req_ready[i] = 1'b1;
                sel_rd       = req_rd[5*i +: 5];
                sel_data     = req_data[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // A grant is only ever issued to a valid requester, so any ready bit is a transfer.
    assign transfer = |req_ready;

    always_comb begin
        num_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            num_valid = num_valid + {1'b0, req_valid[i]};
        end
    end

    assign conflict = !flush && (num_valid >= 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            wb_src       <= '0;
            last_grant   <= 2'd2;
            conflict_cnt <= '0;
        end else begin
            // Writes to x0 are consumed and advance the pointer but never reach the file.
            rf_we <= transfer && (sel_rd != 5'd0);
            if (transfer) begin
                rf_waddr   <= sel_rd;
                rf_wdata   <= sel_data;
                wb_src     <= grant_idx;
                last_grant <= grant_idx;
            end
            if (conflict && (conflict_cnt != {CNT_WIDTH{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic [2:0]  valid;
    logic [4:0]  rd  [3];
    logic [31:0] dat [3];
    logic        flush;

    logic [14:0] req_rd;
    logic [95:0] req_data;
    assign req_rd   = {rd[2], rd[1], rd[0]};
    assign req_data = {dat[2], dat[1], dat[0]};

    logic [2:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [1:0]  wb_src;
    logic [15:0] conflict_cnt;

    logic [2:0]  s_ready;
    logic        s_we;
    logic [4:0]  s_waddr;
    logic [31:0] s_wdata;
    logic [1:0]  s_src;
    logic [3:0]  s_cnt;

    wb_arbiter #(.DATA_WIDTH(32), .NUM_REQ(3), .CNT_WIDTH(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(req_ready), .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .wb_src(wb_src), .conflict_cnt(conflict_cnt)
    );

    wb_arbiter #(.DATA_WIDTH(32), .NUM_REQ(3), .CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(valid), .req_rd(req_rd), .req_data(req_data),
        .req_ready(s_ready), .flush(flush), .rf_we(s_we), .rf_waddr(s_waddr),
        .rf_wdata(s_wdata), .wb_src(s_src), .conflict_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: who won last, and what the write port should show.
    int          m_ptr;
    bit          m_we;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    int          m_src;
    int          m_cnt16;
    int          m_cnt4;
    int          last_win;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner = first valid requester visited when walking 3 slots from last winner + 1.
    function automatic int pick(input logic [2:0] v, input int ptr);
        for (int k = 1; k <= 3; k++) begin
            if (v[(ptr + k) % 3]) return (ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic int pop3(input logic [2:0] v);
        return int'(v[0]) + int'(v[1]) + int'(v[2]);
    endfunction

    task automatic model_reset();
        m_ptr = 2; m_we = 0; m_addr = 0; m_data = 0; m_src = 0;
        m_cnt16 = 0; m_cnt4 = 0; last_win = -1;
    endtask

    // Inputs are already applied (after a falling edge); check grant, clock, check writes.
    task automatic step();
        int g;
        logic [2:0] exp_ready;
        #1;
        g = flush ? -1 : pick(valid, m_ptr);
        exp_ready = (g < 0) ? 3'b000 : 3'(1 << g);
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("sat_req_ready", 64'(s_ready), 64'(exp_ready));
        @(posedge clk);
        if (rst_n) begin
            if (g >= 0) begin
                m_we = (rd[g] != 5'd0); m_addr = rd[g]; m_data = dat[g]; m_src = g; m_ptr = g;
            end else begin
                m_we = 0;
            end
            if (!flush && pop3(valid) >= 2) begin
                m_cnt16 = (m_cnt16 < 65535) ? m_cnt16 + 1 : 65535;
                m_cnt4  = (m_cnt4 < 15) ? m_cnt4 + 1 : 15;
            end
            last_win = g;
        end
        #1;
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_waddr", 64'(rf_waddr), 64'(m_addr));
        chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
        chk("wb_src", 64'(wb_src), 64'(m_src));
        chk("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt16));
        chk("sat_rf_we", 64'(s_we), 64'(m_we));
        chk("sat_rf_wdata", 64'(s_wdata), 64'(m_data));
        chk("sat_rf_waddr", 64'(s_waddr), 64'(m_addr));
        chk("sat_wb_src", 64'(s_src), 64'(m_src));
        chk("sat_conflict_cnt", 64'(s_cnt), 64'(m_cnt4));
        @(negedge clk);
    endtask

    initial begin
        int seen [$];
        model_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        valid = 3'b111;
        rd[0] = 5'd5;  dat[0] = 32'hA1A1A1A1;
        rd[1] = 5'd6;  dat[1] = 32'hB2B2B2B2;
        rd[2] = 5'd7;  dat[2] = 32'hC3C3C3C3;
        @(negedge clk);

        // Reset held two cycles with all requesters valid: nothing registered moves.
        step();
        step();
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_cnt", 64'(conflict_cnt), 64'd0);
        chk("reset_ready", 64'(req_ready), 64'b001);

        // Round robin across all three.
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            seen.push_back(last_win);
        end
        for (int c = 0; c < 6; c++) chk("rr_order", 64'(seen[c]), 64'(c % 3));
        chk("rr_cnt", 64'(conflict_cnt), 64'd6);
        chk("rr_last_addr", 64'(rf_waddr), 64'd7);

        // x0 write is granted and consumed but suppressed at the port.
        valid = 3'b010; rd[1] = 5'd0; dat[1] = 32'hDEADBEEF;
        step();
        chk("x0_we", 64'(rf_we), 64'd0);
        rd[1] = 5'd31;
        step();
        chk("x31_we", 64'(rf_we), 64'd1);
        chk("x31_addr", 64'(rf_waddr), 64'd31);

        // Flush withholds the grant and leaves the pointer alone.
        valid = 3'b011; rd[0] = 5'd4; dat[0] = 32'h11111111; flush = 1'b1;
        step();
        chk("flush_we", 64'(rf_we), 64'd0);
        flush = 1'b0;
        step();
        chk("post_flush_src", 64'(wb_src), 64'd0);

        // Stall hold: req 2 loses once, keeps its data, wins next.
        valid = 3'b100; rd[2] = 5'd8; dat[2] = 32'h22222222;
        step();
        valid = 3'b101; rd[0] = 5'd3; dat[0] = 32'h33333333; rd[2] = 5'd9; dat[2] = 32'hD4D4D4D4;
        step();
        chk("stall_first_src", 64'(wb_src), 64'd0);
        valid = 3'b100;
        step();
        chk("stall_src", 64'(wb_src), 64'd2);
        chk("stall_data", 64'(rf_wdata), 64'hD4D4D4D4);

        // Saturation of the narrow counter.
        valid = 3'b111;
        for (int c = 0; c < 20; c++) step();
        chk("sat_final", 64'(s_cnt), 64'd15);

        // Randomized traffic obeying the requester contract, with one mid-cycle reset.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!(valid[i] && last_win != i)) begin
                    valid[i] = ($urandom_range(0, 3) != 0);
                    rd[i]    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
                    dat[i]   = $urandom;
                end
            end
            flush = ($urandom_range(0, 9) == 0);
            if (c == 200) begin
                #2 rst_n = 1'b0;
                #1;
                model_reset();
                chk("async_rst_we", 64'(rf_we), 64'd0);
                chk("async_rst_cnt", 64'(conflict_cnt), 64'd0);
                chk("async_rst_addr", 64'(rf_waddr), 64'd0);
                @(negedge clk);
                rst_n = 1'b1;
                valid = 3'b000;
                flush = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port among three writeback requesters:
  - req 0: EX/WB path (already-muxed ALU/MEM/PC+4/CSR result).
  - req 1: load-return unit.
  - req 2: multi-cycle mul/div unit.
- Round-robin arbitration with a valid/ready handshake per requester.
- Registered write-port outputs; sits between the writeback mux stage and the register file.
- Counts arbitration conflicts for performance monitoring.

Parameters:
- DATA_WIDTH, 32, width of write data (matches defines.vh).
- NUM_REQ, 3, number of requesters (fixed at 3 in this revision; indices 0..2).
- CNT_WIDTH, 16, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester write request.
- req_rd  input  5*NUM_REQ  destination register per requester; slice i = bits [5i+4:5i].
- req_data  input  DATA_WIDTH*NUM_REQ  write data per requester; slice i as for req_rd.
- req_ready  output  NUM_REQ  grant/accept, one-hot or zero, combinational.
- flush  input  1  pipeline flush; blocks all grants this cycle.
- rf_we  output  1  register-file write enable, registered.
- rf_waddr  output  5  register-file write address, registered.
- rf_wdata  output  DATA_WIDTH  register-file write data, registered.
- wb_src  output  2  index of the requester that produced the current rf_* write, registered.
- conflict_cnt  output  CNT_WIDTH  saturating count of cycles with 2 or more valid requests.

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0, wb_src=0, conflict_cnt=0.
  - RR pointer last_grant=2, so requester 0 has top priority first.
  - Reset asserted mid-operation clears everything immediately; no write is issued after release until a new grant.
- Arbitration (combinational, same cycle):
  - Search order starts at (last_grant+1) mod 3 and wraps.
  - The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - If flush=1, all req_ready=0.
  - A transfer occurs when req_valid[i] && req_ready[i].
- Requester contract:
  - req_rd and req_data are held stable while req_valid=1 and req_ready=0.
  - req_valid may drop only after a transfer, or on the requester's own flush.
- Commit (registered, latency 1):
  - On the edge after a transfer from i: rf_waddr=req_rd[i], rf_wdata=req_data[i], wb_src=i.
  - rf_we=1 unless req_rd[i]==0, in which case rf_we=0. An x0 request is still granted and consumed, and last_grant still advances.
  - No transfer in the cycle: rf_we=0 next cycle; rf_waddr, rf_wdata and wb_src hold their previous values.
- Pointer: last_grant <= i on every transfer. It is unchanged on idle or flush cycles.
- Fairness: a continuously valid requester is granted within at most 3 cycles of first assertion (flush-free).
- Flush:
  - No grant that cycle and rf_we=0 next cycle.
  - A write already registered in the same edge window is not retracted: rf_we driven during the flush cycle itself stands.
- conflict_cnt: increments by 1 each cycle with popcount(req_valid)>=2 and flush=0; saturates at all-ones.
- Single requester valid: granted the same cycle regardless of pointer, giving back-to-back writes every cycle.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles with all req_valid=1.
  - Required: rf_we=0, req outputs unaffected by registers, conflict_cnt=0, wb_src=0.
  - Release, then all three valid: first grant to req 0.
- Round robin:
  - Stimulus: req_valid=3'b111 held 6 cycles; rd 5, 6, 7; data 0xA1A1A1A1, 0xB2B2B2B2, 0xC3C3C3C3.
  - Required: grant sequence 0,1,2,0,1,2; rf_waddr 5,6,7 each one cycle later with matching data and wb_src; conflict_cnt=6.
- x0 suppression:
  - Stimulus: req 1 alone, rd=0, data=0xDEADBEEF.
  - Required: req_ready[1]=1; next cycle rf_we=0.
  - Then rd=31: next cycle rf_we=1, rf_waddr=31.
- Flush:
  - Stimulus: req_valid=3'b011 with flush=1 for 1 cycle.
  - Required: req_ready=0, next-cycle rf_we=0, pointer unchanged.
  - Next cycle, flush=0: grant goes to the same requester that would have won.
- Stall hold:
  - Stimulus: req 2 valid while req 0 wins.
  - Required: req 2 granted by the following cycle with its held data 0xD4D4D4D4; no data loss.
- Counter saturation:
  - Stimulus: CNT_WIDTH=4, 20 conflict cycles.
  - Required: conflict_cnt=15, no wrap.
